dmi_responder: RTL and testbench

DMI_RESPONDER -- requirements
Module: dmi_responder

---
 rtl/dmi_responder_pkg.sv | 19 +
 rtl/dmi_responder_regfile.sv | 27 ++
 rtl/dmi_responder.sv | 91 +++++++++
 tb/tb_dmi_responder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmi_responder_pkg.sv
// dmi_responder_pkg: shared debug-module encodings, DMI request/response structs and FSM states.
package dmi_responder_pkg;
  typedef enum logic [1:0] {DMI_NOP = 2'h0, DMI_READ = 2'h1, DMI_WRITE = 2'h2} dm_op_e;
  typedef enum logic [1:0] {DMI_SUCCESS = 2'h0, DMI_FAILED = 2'h2, DMI_BUSY = 2'h3} dm_resp_e;
  // op stays a raw 2-bit field because the reserved code 3 must travel through unchanged
  typedef struct packed {
    logic [6:0]  addr;
    logic [31:0] data;
    logic [1:0]  op;
  } dmi_req_t;
  typedef struct packed {
    logic [31:0] data;
    dm_resp_e    resp;
  } dmi_resp_t;
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_e;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/dmi_responder_regfile.sv
// dmi_responder_regfile: register bank with one write port, one read mux and a flat regs_o view.
module dmi_responder_regfile import dmi_responder_pkg::*; #(
  parameter int NumRegs = 12,
  parameter int IdxW    = idx_w(NumRegs)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    we_i,
  input  logic [IdxW-1:0]         idx_i,
  input  logic [31:0]             wdata_i,
  output logic [31:0]             rdata_o,
  output logic [NumRegs*32-1:0]   regs_o
);
  logic [31:0] r_regs [NumRegs];
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumRegs; i++) r_regs[i] <= '0;
    end else if (we_i) begin
      r_regs[idx_i] <= wdata_i;
    end
  end
  // a truncated index from an out-of-range address may exceed the bank
  assign rdata_o = 32'(idx_i) < NumRegs ? r_regs[idx_i] : '0;
  for (genvar g = 0; g < NumRegs; g++) begin : g_flat
    assign regs_o[32*g +: 32] = r_regs[g];
  end
endmodule

// File: rtl/dmi_responder.sv
// dmi_responder: DMI register responder with an IDLE/ACCESS/RESP FSM and programmable access latency.
// Define DMI_RESP_ADDR_CHECK_EN to fail out-of-range READ/WRITE instead of silently absorbing them.
module dmi_responder import dmi_responder_pkg::*; #(
  parameter int         NumRegs       = 12,
  parameter logic [6:0] BaseAddr      = 7'h04,
  parameter int         AccessLatency = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  dmi_req_t              dmi_req_i,
  input  logic                  dmi_req_valid_i,
  output logic                  dmi_req_ready_o,
  output dmi_resp_t             dmi_resp_o,
  output logic                  dmi_resp_valid_o,
  input  logic                  dmi_resp_ready_i,
  output logic [NumRegs*32-1:0] regs_o
);
  localparam int IdxW = idx_w(NumRegs);
  state_e          r_state;
  logic [3:0]      r_cnt;
  dmi_req_t        r_req;
  logic            r_ready;
  logic            r_resp_valid;
  dmi_resp_t       r_resp;
  dmi_resp_t       w_resp;
  logic            w_in_range;
  logic            w_rd;
  logic            w_wr;
  logic            w_we;
  logic            w_fail;
  logic [IdxW-1:0] w_idx;
  logic [31:0]     w_rdata;
  // widened upper bound so BaseAddr+NumRegs == 128 does not wrap
  assign w_in_range = r_req.addr >= BaseAddr && 8'(r_req.addr) < 8'(BaseAddr) + 8'(NumRegs);
  assign w_idx      = IdxW'(r_req.addr - BaseAddr);
  assign w_rd       = r_req.op == DMI_READ;
  assign w_wr       = r_req.op == DMI_WRITE;
  assign w_we       = r_state == S_ACCESS && r_cnt == '0 && w_wr && w_in_range;
`ifdef DMI_RESP_ADDR_CHECK_EN
  assign w_fail = &r_req.op || ((w_rd || w_wr) && !w_in_range);
`else
  assign w_fail = &r_req.op;
`endif
  assign w_resp = '{data: (w_in_range && w_rd) ? w_rdata : (w_in_range && w_wr) ? r_req.data : 32'h0,
                    resp: w_fail ? DMI_FAILED : DMI_SUCCESS};
  dmi_responder_regfile #(.NumRegs(NumRegs), .IdxW(IdxW)) u_regfile (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we_i    (w_we),
    .idx_i   (w_idx),
    .wdata_i (r_req.data),
    .rdata_o (w_rdata),
    .regs_o  (regs_o)
  );
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_req        <= '0;
      r_ready      <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp       <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (dmi_req_valid_i) begin
          r_req   <= dmi_req_i;
          r_cnt   <= 4'(AccessLatency);
          r_ready <= 1'b0;
          r_state <= S_ACCESS;
        end
        S_ACCESS: if (r_cnt != '0) begin
          r_cnt <= r_cnt - 4'd1;
        end else begin
          r_resp       <= w_resp;
          r_resp_valid <= 1'b1;
          r_state      <= S_RESP;
        end
        S_RESP: if (dmi_resp_ready_i) begin
          r_resp       <= '0;
          r_resp_valid <= 1'b0;
          r_ready      <= 1'b1;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign dmi_req_ready_o  = r_ready;
  assign dmi_resp_valid_o = r_resp_valid;
  assign dmi_resp_o       = r_resp;
endmodule

// File: tb/tb_dmi_responder.sv
// tb_dmi_responder: two responders (AccessLatency 1 and 0) checked against a per-cycle transaction model.
module tb_dmi_responder;
`ifdef DMI_RESP_ADDR_CHECK_EN
  localparam logic [1:0] OOR = 2'h2;
`else
  localparam logic [1:0] OOR = 2'h0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [40:0]  req [2];
  logic         valid [2];
  logic         rready [2];
  logic         rdy [2];
  logic         rv [2];
  logic [33:0]  resp [2];
  logic [383:0] regs [2];
  int n_cmp = 0;
  int n_fail = 0;
  always #5 clk = ~clk;

  dmi_responder #(.NumRegs(12), .BaseAddr(7'h04), .AccessLatency(1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .dmi_req_i(req[0]), .dmi_req_valid_i(valid[0]),
    .dmi_req_ready_o(rdy[0]), .dmi_resp_o(resp[0]), .dmi_resp_valid_o(rv[0]),
    .dmi_resp_ready_i(rready[0]), .regs_o(regs[0]));
  dmi_responder #(.NumRegs(12), .BaseAddr(7'h04), .AccessLatency(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .dmi_req_i(req[1]), .dmi_req_valid_i(valid[1]),
    .dmi_req_ready_o(rdy[1]), .dmi_resp_o(resp[1]), .dmi_resp_valid_o(rv[1]),
    .dmi_resp_ready_i(rready[1]), .regs_o(regs[1]));

  task automatic chk(input string nm, input logic [383:0] act, input logic [383:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // transaction-level model: one outstanding request per DUT, response due L+2 cycles after accept
  bit        busy [2];
  int        hs [2];
  logic [33:0] expr [2];
  bit [31:0] mregs [2][12];
  bit        pv [2];
  int        pidx [2];
  bit [31:0] pdata [2];
  int        cyc = 0;

  function automatic int lat_of(input int s);
    return s == 0 ? 1 : 0;
  endfunction
  function automatic bit inr(input logic [6:0] a);
    return a >= 7'h04 && a < 7'h10;
  endfunction
  function automatic logic [33:0] exp_of(input int s, input logic [40:0] q);
    logic [6:0] a;
    logic [1:0] op;
    a = q[40:34];
    op = q[1:0];
    if (op == 2'h3) return {32'h0, 2'h2};
    if (op == 2'h0) return '0;
    if (!inr(a)) return {32'h0, OOR};
    return op == 2'h1 ? {mregs[s][int'(a) - 4], 2'h0} : {q[33:2], 2'h0};
  endfunction
  function automatic logic [383:0] flat(input int s);
    logic [383:0] f;
    for (int i = 0; i < 12; i++) f[32*i +: 32] = mregs[s][i];
    return f;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < 2; s++) begin
        busy[s] <= 1'b0;
        pv[s] <= 1'b0;
        for (int i = 0; i < 12; i++) mregs[s][i] <= '0;
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (pv[s] && cyc == hs[s] + lat_of(s) + 1) begin
          mregs[s][pidx[s]] <= pdata[s];
          pv[s] <= 1'b0;
        end
        if (busy[s]) begin
          if (cyc >= hs[s] + lat_of(s) + 2 && rready[s]) busy[s] <= 1'b0;
        end else if (valid[s]) begin
          busy[s] <= 1'b1;
          hs[s] <= cyc;
          expr[s] <= exp_of(s, req[s]);
          if (req[s][1:0] == 2'h2 && inr(req[s][40:34])) begin
            pv[s] <= 1'b1;
            pidx[s] <= int'(req[s][40:34]) - 4;
            pdata[s] <= req[s][33:2];
          end
        end
      end
      cyc <= cyc + 1;
    end
  end

  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      bit ev;
      ev = busy[s] && cyc >= hs[s] + lat_of(s) + 2;
      chk($sformatf("ready%0d", s), rdy[s], !busy[s]);
      chk($sformatf("valid%0d", s), rv[s], ev);
      chk($sformatf("resp%0d", s), resp[s], ev ? expr[s] : 34'h0);
      chk($sformatf("regs%0d", s), regs[s], flat(s));
    end
  end

  task automatic txn(input int s, input logic [6:0] a, input logic [31:0] d, input logic [1:0] op,
                     output logic [33:0] r, output int lat);
    int n;
    bit h;
    req[s] = {a, d, op};
    valid[s] = 1'b1;
    rready[s] = 1'b1;
    n = 0;
    do begin
      h = rdy[s];
      @(posedge clk);
      #1;
      n++;
    end while (!h && n < 50);
    chk("accept", h, 1);
    valid[s] = 1'b0;
    req[s] = 41'({$urandom(), $urandom()});
    lat = 1;
    while (!rv[s] && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    r = resp[s];
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    logic [33:0] r;
    int l;
    int n;
    for (int s = 0; s < 2; s++) begin
      req[s] = '0;
      valid[s] = 1'b0;
      rready[s] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    txn(0, 7'h04, 32'hDEADBEEF, 2'h2, r, l);
    chk("w04_resp", r, {32'hDEADBEEF, 2'h0});
    chk("w04_lat", l, 3);
    chk("w04_reg", regs[0][31:0], 32'hDEADBEEF);
    txn(0, 7'h04, 32'h0, 2'h1, r, l);
    chk("r04_resp", r, {32'hDEADBEEF, 2'h0});
    txn(0, 7'h7F, 32'h0, 2'h1, r, l);
    chk("r7f_resp", r, {32'h0, OOR});
    txn(0, 7'h04, 32'hFFFFFFFF, 2'h3, r, l);
    chk("op3_resp", r, {32'h0, 2'h2});
    chk("op3_reg", regs[0][31:0], 32'hDEADBEEF);
    txn(0, 7'h0F, 32'h0BADF00D, 2'h2, r, l);
    chk("w0f_resp", r, {32'h0BADF00D, 2'h0});
    chk("w0f_reg", regs[0][383:352], 32'h0BADF00D);
    txn(0, 7'h10, 32'h11111111, 2'h2, r, l);
    chk("w10_resp", r, {32'h0, OOR});
    txn(0, 7'h03, 32'h22222222, 2'h2, r, l);
    chk("w03_resp", r, {32'h0, OOR});
    chk("w03_reg0", regs[0][31:0], 32'hDEADBEEF);
    txn(0, 7'h05, 32'h33333333, 2'h0, r, l);
    chk("nop_resp", r, 34'h0);
    chk("nop_reg1", regs[0][63:32], 32'h0);
    txn(0, 7'h0F, 32'h0, 2'h1, r, l);
    chk("r0f_resp", r, {32'h0BADF00D, 2'h0});
    // backpressure: response held 10 cycles while a second request waits
    req[0] = {7'h04, 32'h0, 2'h1};
    valid[0] = 1'b1;
    rready[0] = 1'b0;
    @(posedge clk);
    #1;
    req[0] = {7'h06, 32'hA5A5A5A5, 2'h2};
    n = 0;
    while (!rv[0] && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (10) begin
      chk("bp_resp", resp[0], {32'hDEADBEEF, 2'h0});
      chk("bp_rdy", rdy[0], 0);
      @(posedge clk);
      #1;
    end
    rready[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_idle_rdy", rdy[0], 1);
    chk("bp_rv_drop", rv[0], 0);
    @(posedge clk);
    #1;
    chk("bp_accept", rdy[0], 0);
    valid[0] = 1'b0;
    n = 0;
    while (!rv[0] && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("bp_w06_resp", resp[0], {32'hA5A5A5A5, 2'h0});
    @(posedge clk);
    #1;
    chk("bp_w06_reg", regs[0][95:64], 32'hA5A5A5A5);
    txn(1, 7'h04, 32'hCAFEF00D, 2'h2, r, l);
    chk("l0_w_resp", r, {32'hCAFEF00D, 2'h0});
    chk("l0_w_lat", l, 2);
    txn(1, 7'h04, 32'h0, 2'h1, r, l);
    chk("l0_r_resp", r, {32'hCAFEF00D, 2'h0});
    chk("l0_r_lat", l, 2);
    txn(1, 7'h7F, 32'h0, 2'h1, r, l);
    chk("l0_r7f_resp", r, {32'h0, OOR});
    txn(1, 7'h08, 32'h5, 2'h3, r, l);
    chk("l0_op3_resp", r, {32'h0, 2'h2});
    // reset while a write to 7'h05 sits in ACCESS
    req[0] = {7'h05, 32'h12345678, 2'h2};
    valid[0] = 1'b1;
    rready[0] = 1'b1;
    @(posedge clk);
    #1;
    valid[0] = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("rst_rv", rv[0], 0);
    chk("rst_rdy", rdy[0], 1);
    chk("rst_regs", regs[0], 384'h0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_regs", regs[0], 384'h0);
    chk("post_rst_reg1", regs[0][63:32], 32'h0);
    chk("post_rst_rv", rv[0], 0);
    chk("post_rst_rdy", rdy[0], 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
